// File: rtl/id_check_pkg.sv
// id_check_pkg: shared FSM encoding and ID block layout for the ID check master
package id_check_pkg;
  typedef enum logic [1:0] {IDLE, RD, GAP, DONE} state_t;
  localparam int WORD_COUNT = 3;
  localparam logic [1:0] LAST_INDEX = 2'(WORD_COUNT - 1);
  localparam logic [31:0] WORD_OFFSET [WORD_COUNT] = '{32'd0, 32'd4, 32'd8};
endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: per-access wait timer, flags expiry at TIMEOUT-1
module bus_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iClr,
  input  logic iEn,
  output logic oExpired
);
  logic [7:0] count;
  assign oExpired = count == 8'(TIMEOUT - 1);
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) count <= '0;
    else if (iClr) count <= '0;
    else if (iEn && !oExpired) count <= count + 8'd1;
  end
endmodule

// File: rtl/id_check_master.sv
// id_check_master: reads the three-word ID block and reports match/mismatch/timeout
module id_check_master import id_check_pkg::*; #(
  parameter logic [31:0] BaseAddr = 32'h0200_0100,
  parameter logic [31:0] ID_VER1  = 32'h0123_4567,
  parameter logic [31:0] ID_VER2  = 32'h89AB_CDEF,
  parameter logic [31:0] ID_VER3  = 32'hFEDC_BA98,
  parameter int          TIMEOUT  = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  output logic [31:0] oADR,
  input  logic [31:0] iDAT,
  output logic        oSTB,
  output logic        oWE,
  input  logic        iACK,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oPASS,
  output logic [2:0]  oMISMATCH,
  output logic        oTMO
);
  state_t state;
  logic [1:0] index;
  logic [31:0] expWord;
  logic tmrExpired;
  assign oWE = 1'b0;
  assign expWord = index == 2'd0 ? ID_VER1 : index == 2'd1 ? ID_VER2 : ID_VER3;
  // Timer runs only while strobing; leaving RD always restarts it from zero.
  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) timer (
    .iCLK(iCLK),
    .iRST(iRST),
    .iClr(state != RD),
    .iEn(!iACK),
    .oExpired(tmrExpired)
  );
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= IDLE;
      index <= '0;
      oADR <= '0;
      oSTB <= 1'b0;
      oBUSY <= 1'b0;
      oDONE <= 1'b0;
      oPASS <= 1'b0;
      oMISMATCH <= '0;
      oTMO <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      case (state)
        IDLE: if (iSTART) begin
          state <= RD;
          index <= '0;
          oADR <= BaseAddr + WORD_OFFSET[0];
          oSTB <= 1'b1;
          oBUSY <= 1'b1;
          oPASS <= 1'b0;
          oMISMATCH <= '0;
          oTMO <= 1'b0;
        end
        RD: if (iACK) begin
          state <= GAP;
          oSTB <= 1'b0;
          if (iDAT != expWord) oMISMATCH[index] <= 1'b1;
        end else if (tmrExpired) begin
          state <= DONE;
          oSTB <= 1'b0;
          oTMO <= 1'b1;
          oDONE <= 1'b1;
        end
        GAP: if (index == LAST_INDEX) begin
          state <= DONE;
          oDONE <= 1'b1;
          oPASS <= oMISMATCH == '0 && !oTMO;
        end else begin
          state <= RD;
          index <= index + 2'd1;
          oADR <= BaseAddr + WORD_OFFSET[index + 2'd1];
          oSTB <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_id_check_master.sv
// tb_id_check_master: table-driven scoreboard bench with a configurable slave model
module tb_id_check_master;
  localparam logic [31:0] BASE = 32'h0200_0100;
  localparam logic [31:0] ID1 = 32'h0123_4567;
  localparam logic [31:0] ID2 = 32'h89AB_CDEF;
  localparam logic [31:0] ID3 = 32'hFEDC_BA98;
  localparam int NONE = 9;
  localparam int LIMIT = 300;

  typedef struct {
    int waits;
    int corruptIdx;
    logic [31:0] corruptVal;
    int noAckIdx;
    int busyPulse;
    int lat;
    logic [2:0] mis;
    logic tmo;
    logic pass;
  } vec_t;

  logic iCLK = 1'b0, iRST = 1'b0, iSTART = 1'b0, iACK;
  logic [31:0] iDAT, oADR;
  logic oSTB, oWE, oBUSY, oDONE, oPASS, oTMO;
  logic [2:0] oMISMATCH;
  int waits = 0, corruptIdx = NONE, noAckIdx = NONE, waitCnt;
  logic [31:0] corruptVal = '0;
  int compared = 0, mismatched = 0, addrErr = 0, weErr = 0;
  int slaveIdx;
  vec_t vecs[7];
  vec_t sb[$];

  id_check_master dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .oADR(oADR), .iDAT(iDAT),
    .oSTB(oSTB), .oWE(oWE), .iACK(iACK), .oBUSY(oBUSY), .oDONE(oDONE),
    .oPASS(oPASS), .oMISMATCH(oMISMATCH), .oTMO(oTMO)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [31:0] idWord(input int i);
    return i == 0 ? ID1 : i == 1 ? ID2 : ID3;
  endfunction

  // Slave: acks once the strobe has waited 'waits' cycles, optionally never for one word.
  always_comb begin
    slaveIdx = int'((oADR - BASE) >> 2);
    iACK = oSTB && waitCnt >= waits && slaveIdx != noAckIdx;
    iDAT = iACK ? (slaveIdx == corruptIdx ? corruptVal : idWord(slaveIdx)) : 'x;
  end

  always @(posedge iCLK or negedge iRST)
    if (!iRST) waitCnt <= 0;
    else waitCnt <= (oSTB && !iACK) ? waitCnt + 1 : 0;

  always @(negedge iCLK) begin
    if (oSTB && (oADR < BASE || oADR > BASE + 32'd8 || oADR[1:0] != 2'b00)) addrErr++;
    if (oWE) weErr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runCheck(input vec_t v);
    vec_t e;
    int n, extra;
    waits = v.waits;
    corruptIdx = v.corruptIdx;
    corruptVal = v.corruptVal;
    noAckIdx = v.noAckIdx;
    iSTART = 1'b1;
    sb.push_back(v);
    @(negedge iCLK);
    n = 1;
    iSTART = 1'b0;
    check("busy_after_start", oBUSY, 1);
    while (!oDONE && n < LIMIT) begin
      iSTART = (n == v.busyPulse);
      @(negedge iCLK);
      n++;
    end
    iSTART = 1'b0;
    e = sb.pop_front();
    if (n >= LIMIT) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: no oDONE within %0d cycles", LIMIT);
      return;
    end
    check("latency", n, e.lat);
    check("mismatch", oMISMATCH, e.mis);
    check("tmo", oTMO, e.tmo);
    check("pass", oPASS, e.pass);
    check("busy_at_done", oBUSY, 1);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      if (oDONE) extra++;
    end
    check("extra_done", extra, 0);
    check("busy_after_done", oBUSY, 0);
    check("pass_held", oPASS, e.pass);
    check("mismatch_held", oMISMATCH, e.mis);
  endtask

  initial begin
    vec_t nominal;
    int dones;
    // waits, corruptIdx, corruptVal, noAckIdx, busyPulse, lat, mis, tmo, pass
    vecs[0] = '{0, NONE, 32'h0, NONE, -1, 7, 3'b000, 1'b0, 1'b1};
    vecs[1] = '{0, 1, 32'h89AB_CDE0, NONE, -1, 7, 3'b010, 1'b0, 1'b0};
    vecs[2] = '{0, NONE, 32'h0, 2, -1, 21, 3'b000, 1'b1, 1'b0};
    vecs[3] = '{2, NONE, 32'h0, NONE, 3, 13, 3'b000, 1'b0, 1'b1};
    vecs[4] = '{1, 2, 32'hFEDC_BA99, NONE, 5, 10, 3'b100, 1'b0, 1'b0};
    vecs[5] = '{15, NONE, 32'h0, NONE, -1, 52, 3'b000, 1'b0, 1'b1};
    vecs[6] = '{16, 0, 32'h0, NONE, -1, 17, 3'b000, 1'b1, 1'b0};
    nominal = vecs[0];
    #3;
    check("reset_outputs", {oSTB, oWE, oADR, oBUSY, oDONE, oPASS, oMISMATCH, oTMO}, 0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;
    foreach (vecs[i]) runCheck(vecs[i]);
    // Reset during the second read: strobe must drop at once, no done pulse.
    waits = 0;
    corruptIdx = NONE;
    noAckIdx = NONE;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK);
    check("stb_second_rd", oSTB, 1);
    check("adr_second_rd", oADR, BASE + 32'd4);
    #2 iRST = 1'b0;
    #1;
    check("stb_async_drop", oSTB, 0);
    check("busy_async_drop", oBUSY, 0);
    check("adr_async_clear", oADR, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iCLK);
      if (oDONE) dones++;
    end
    check("no_done_in_reset", dones, 0);
    iRST = 1'b1;
    runCheck(nominal);
    check("addr_range", addrErr, 0);
    check("we_zero", weErr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/id_check_master.md
ID_CHECK_MASTER -- requirements
Module: id_check_master

Interface
REQ-001 Parameter BaseAddr, 32'h0200_0100, base address of the three-word ID block on the slave bus.
REQ-002 Parameter ID_VER1, 32'h0123_4567, expected word at BaseAddr+0.
REQ-003 Parameter ID_VER2, 32'h89AB_CDEF, expected word at BaseAddr+4.
REQ-004 Parameter ID_VER3, 32'hFEDC_BA98, expected word at BaseAddr+8.
REQ-005 Parameter TIMEOUT, 16, maximum cycles STB may wait for ACK per access (range 2..255).
REQ-006 iCLK  input  1  single clock, all state on rising edge.
REQ-007 iRST  input  1  reset, asynchronous, active-low.
REQ-008 iSTART  input  1  check request, sampled high in IDLE only.
REQ-009 oADR  output  32  bus address.
REQ-010 iDAT  input  32  bus read data, valid only while iACK=1.
REQ-011 oSTB  output  1  bus strobe, active high.
REQ-012 oWE  output  1  write enable, constant 0 (read-only master).
REQ-013 iACK  input  1  slave acknowledge, may be combinational from oSTB/oADR.
REQ-014 oBUSY  output  1  high from cycle after iSTART accepted until DONE cycle inclusive.
REQ-015 oDONE  output  1  one-cycle completion pulse.
REQ-016 oPASS  output  1  all three words matched, no timeout; held until next accepted iSTART.
REQ-017 oMISMATCH  output  3  bit i set if word i read and differed from expected; held like oPASS.
REQ-018 oTMO  output  1  access timed out; held like oPASS.

Function
REQ-019 FSM states SHALL be IDLE, RD, GAP, DONE.
REQ-020 IDLE: oSTB=0; iSTART=1 -> RD, index=0, timer=0, oPASS/oMISMATCH/oTMO cleared.
REQ-021 RD: oSTB=1, oWE=0, oADR=BaseAddr+4*index, registered outputs (no combinational path from iACK).
REQ-022 RD with iACK=1: compare iDAT to expected word for index; mismatch sets oMISMATCH[index]; -> GAP.
REQ-023 RD with iACK=0: timer increments; when timer reaches TIMEOUT-1 without iACK -> DONE with oTMO=1, remaining words not read.
REQ-024 GAP: oSTB=0 for exactly one cycle; index=2 -> DONE, else index+1, timer=0 -> RD.
REQ-025 DONE: oDONE=1 for one cycle, oPASS=(oMISMATCH==0)&~oTMO valid in the same cycle; -> IDLE.
REQ-026 A mismatch SHALL NOT abort the sequence; all three words are always read unless timeout.
REQ-027 iSTART outside IDLE SHALL be ignored (no queuing).
REQ-028 Zero-wait slave: oDONE SHALL assert 7 cycles after the iSTART sampling edge (RD,GAP x3, DONE).
REQ-029 Each wait cycle on iACK SHALL add exactly one cycle to total latency.
REQ-030 Index SHALL never exceed 2; oADR SHALL never leave BaseAddr..BaseAddr+8 while oSTB=1.
REQ-031 iDAT SHALL be ignored (may be Z/X) whenever iACK=0.

Reset
REQ-032 iRST low SHALL immediately force IDLE, oSTB=0, oWE=0, oADR=0, oBUSY=0, oDONE=0, oPASS=0, oMISMATCH=0, oTMO=0, index=0, timer=0.
REQ-033 Reset mid-access SHALL drop oSTB asynchronously; no oDONE pulse for the aborted check.
REQ-034 First iSTART SHALL be accepted on the first rising edge after iRST deasserts.

Structure
REQ-035 Shared package id_check_pkg SHALL hold FSM state encoding, word offsets (0,4,8) and word count (3).
REQ-036 One sub-module bus_timeout_cnt (clear, enable, expiry at TIMEOUT-1) SHALL implement the timer; rest is a single FSM.

Verification
REQ-037 Default params, slave returning the three default IDs, zero-wait; iSTART pulse -> oDONE 7 cycles later, oPASS=1, oMISMATCH=000, oTMO=0.
REQ-038 Slave returns 32'h89AB_CDE0 at BaseAddr+4 -> three reads completed, oMISMATCH=010, oPASS=0.
REQ-039 Slave never ACKs BaseAddr+8 -> oTMO=1 after 16 RD cycles on that word, oMISMATCH=000, oPASS=0, oDONE once.
REQ-040 Slave with 2 wait cycles per access -> oDONE 13 cycles after iSTART, oPASS=1; iSTART pulsed during busy ignored.
REQ-041 iRST low during second RD -> oSTB=0 same cycle, no oDONE; new iSTART after release -> normal 7-cycle pass.
